rmst_to_ram_tile: RTL

// Load-side counterpart of the tile store path: moves param_iolen 32-bit words from external memory
// at param_raddr into an on-chip RAM tile through the Avalon read master (master-template control/user ports).

---
 rtl/accel_pkg.sv | 17 +
 rtl/rmst_to_ram_tile_xdw_unpack.sv | 61 ++++++
 rtl/rmst_to_ram_tile.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// Shared constants and FSM encoding for the tile load path (rmst_to_ram_tile).
package accel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Words per burst command
    localparam int unsigned BLEN       = 8;
    // Words per read-master beat
    localparam int unsigned WCNT       = 4;
    // log2(bytes per word)
    localparam int unsigned BYTE_SHIFT = 2;

endpackage

// File: rtl/rmst_to_ram_tile_xdw_unpack.sv
// Beat unpacker: holds one XDW-bit beat and emits it as DW-bit words, low word first.
module xdw_unpack
    import accel_pkg::*;
#(
    parameter int unsigned DW  = 32,
    parameter int unsigned XDW = 128
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [XDW-1:0] beat_in,
    output logic [DW-1:0]  word_out,
    output logic           valid,
    output logic           last
);

    localparam int unsigned WPB = XDW / DW;
    localparam int unsigned IW  = (WPB > 1) ? $clog2(WPB) : 1;

    logic [XDW-1:0] beat_q, beat_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           valid_q, valid_d;

    assign word_out = beat_q[DW-1:0];
    assign valid    = valid_q;
    assign last     = valid_q && (idx_q == IW'(WPB - 1));

    // Load a new beat, otherwise shift the next word down into the output slot
    always_comb begin
        beat_d  = beat_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (load) begin
            beat_d  = beat_in;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (valid_q) begin
            if (last) begin
                valid_d = 1'b0;
                idx_d   = '0;
            end else begin
                beat_d = beat_q >> DW;
                idx_d  = idx_q + IW'(1);
            end
        end
    end

    // Beat/index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            beat_q  <= beat_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/rmst_to_ram_tile.sv
// Loads iolen words from external memory into the tile RAM via the Avalon read master.
// Optional RMST_PERF_CNT_EN adds a load_cycles run-time counter port.
module rmst_to_ram_tile
    import accel_pkg::*;
#(
    parameter int unsigned AW          = 12,
    parameter int unsigned CW          = 6,
    parameter int unsigned DW          = 32,
    parameter int unsigned XAW         = 32,
    parameter int unsigned XDW         = 128,
    parameter int unsigned MAX_PENDING = 16
) (
    input  logic           clk,
    input  logic           rst,
    output logic           rmst_fixed_location,
    output logic [XAW-1:0] rmst_read_base,
    output logic [CW-1:0]  rmst_read_length,
    output logic           rmst_go,
    input  logic           rmst_done,
    output logic           rmst_user_read_buffer,
    input  logic [XDW-1:0] rmst_user_buffer_data,
    input  logic           rmst_user_data_available,
    input  logic           config_done,
    input  logic [AW-1:0]  param_iolen,
    input  logic [XAW-1:0] param_raddr,
    input  logic           load_data_start,
    output logic           load_data_done,
    output logic [DW-1:0]  rmst_wr_data,
    output logic [AW-1:0]  rmst_wr_addr,
    output logic           rmst_wr_ena
`ifdef RMST_PERF_CNT_EN
    ,
    output logic [31:0]    load_cycles
`endif
);

    localparam int unsigned CNTW       = AW + 1;
    localparam int unsigned WPB        = XDW / DW;
    localparam int unsigned PEND_LIMIT = MAX_PENDING * BLEN;

    state_e          state_q, state_d;
    logic [AW-1:0]   iolen_q, iolen_d;
    logic [XAW-1:0]  raddr_q, raddr_d;
    logic [XAW-1:0]  base_q, base_d;
    logic [CW-1:0]   len_q, len_d;
    logic            go_q, go_d;
    logic            done_q, done_d;
    logic [CNTW-1:0] issued_q, issued_d;
    logic [CNTW-1:0] popped_q, popped_d;
    logic [CNTW-1:0] written_q, written_d;

    logic [CNTW-1:0] iolen_ext;
    logic [CNTW-1:0] remain;
    logic [CNTW-1:0] burst_words;
    logic [CNTW-1:0] written_inc;
    logic [31:0]     pending;
    logic            issue_ok;
    logic            start_c;
    logic            pop_c;

    logic [DW-1:0]   up_word;
    logic            up_valid;
    logic            up_last;

    // Flow-control terms for burst issue and beat pop
    always_comb begin
        iolen_ext   = CNTW'(iolen_q);
        remain      = iolen_ext - issued_q;
        burst_words = (remain < CNTW'(BLEN)) ? remain : CNTW'(BLEN);
        written_inc = written_q + CNTW'(up_valid);
        pending     = 32'(issued_q) - 32'(popped_q);
        start_c     = load_data_start && (state_q != ST_RUN);
        // rmst_done lags go by a cycle, so never issue right after a go
        issue_ok    = (state_q == ST_RUN) && rmst_done && (issued_q < iolen_ext) && !go_q
                      && ((pending + 32'(BLEN)) <= 32'(PEND_LIMIT));
        // Beats beyond iolen are left in the FIFO
        pop_c       = !rst && (state_q == ST_RUN) && rmst_user_data_available
                      && (!up_valid || up_last) && (popped_q < iolen_ext);
    end

    // Next-state, burst issue and counters
    always_comb begin
        state_d   = state_q;
        iolen_d   = iolen_q;
        raddr_d   = raddr_q;
        base_d    = base_q;
        len_d     = len_q;
        go_d      = 1'b0;
        done_d    = done_q;
        issued_d  = issued_q;
        popped_d  = popped_q;
        written_d = written_q;

        if (go_q) begin
            base_d = base_q + XAW'(len_q);
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_c) begin
                    state_d   = (iolen_q == '0) ? ST_DONE : ST_RUN;
                    done_d    = (iolen_q == '0);
                    base_d    = raddr_q;
                    issued_d  = '0;
                    popped_d  = '0;
                    written_d = '0;
                end else if (config_done) begin
                    iolen_d = param_iolen;
                    raddr_d = param_raddr;
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (issue_ok) begin
                    go_d     = 1'b1;
                    len_d    = CW'(burst_words << BYTE_SHIFT);
                    issued_d = issued_q + burst_words;
                end
                if (pop_c) begin
                    popped_d = popped_q + CNTW'(WPB);
                end
                written_d = written_inc;
                if (written_inc == iolen_ext) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            iolen_q   <= '0;
            raddr_q   <= '0;
            base_q    <= '0;
            len_q     <= '0;
            go_q      <= 1'b0;
            done_q    <= 1'b0;
            issued_q  <= '0;
            popped_q  <= '0;
            written_q <= '0;
        end else begin
            state_q   <= state_d;
            iolen_q   <= iolen_d;
            raddr_q   <= raddr_d;
            base_q    <= base_d;
            len_q     <= len_d;
            go_q      <= go_d;
            done_q    <= done_d;
            issued_q  <= issued_d;
            popped_q  <= popped_d;
            written_q <= written_d;
        end
    end

    xdw_unpack #(
        .DW  (DW),
        .XDW (XDW)
    ) u_unpack (
        .clk      (clk),
        .rst      (rst),
        .load     (pop_c),
        .beat_in  (rmst_user_buffer_data),
        .word_out (up_word),
        .valid    (up_valid),
        .last     (up_last)
    );

    assign rmst_fixed_location   = 1'b0;
    assign rmst_read_base        = base_q;
    assign rmst_read_length      = len_q;
    assign rmst_go               = go_q;
    assign rmst_user_read_buffer = pop_c;
    assign load_data_done        = done_q;
    assign rmst_wr_data          = up_word;
    assign rmst_wr_addr          = AW'(written_q);
    assign rmst_wr_ena           = up_valid;

`ifdef RMST_PERF_CNT_EN
    logic [31:0] cyc_q, cyc_d;

    // Saturating count of RUN cycles, cleared on start
    always_comb begin
        cyc_d = cyc_q;
        if (start_c) begin
            cyc_d = '0;
        end else if ((state_q == ST_RUN) && (cyc_q != '1)) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    // Cycle counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign load_cycles = cyc_q;
`endif

endmodule
